// File: rtl/pb_debounce_pkg.sv
// Shared constants and types for the push-button debounce/detect block.
package pb_debounce_pkg;

  localparam int NUM_PB        = 4;      // push-button channels
  localparam int SAMPLE_PERIOD = 50000;  // clock cycles per debounce sample (1 kHz at 50 MHz)
  localparam int SHIFT_LEN     = 10;     // samples of history per channel
  localparam int HOLD_TICKS    = 1000;   // samples of continuous press before long-press
  localparam int HOLD_CNT_W    = 11;     // hold counter width, covers HOLD_TICKS up to 2047

  typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

endpackage

// File: rtl/pb_debounce_if.sv
// Debounced push-button status bundle: driven by the detector, read by consumers.
interface pb_debounce_if #(
  parameter int NUM_PB = pb_debounce_pkg::NUM_PB
);

  logic              sample_tick;
  logic [NUM_PB-1:0] pb_status;
  logic [NUM_PB-1:0] pb_pressed;
  logic [NUM_PB-1:0] pb_released;
  logic [NUM_PB-1:0] pb_held;

  modport master (
    output sample_tick, pb_status, pb_pressed, pb_released, pb_held
  );

  modport slave (
    input sample_tick, pb_status, pb_pressed, pb_released, pb_held
  );

endinterface

// File: rtl/pb_debounce_channel.sv
// One push-button channel: synchroniser, sample history, debounced level,
// press/release edge pulses and long-press hold detection.
module pb_debounce_channel
  import pb_debounce_pkg::*;
#(
  parameter int SHIFT_LEN  = pb_debounce_pkg::SHIFT_LEN,
  parameter int HOLD_TICKS = pb_debounce_pkg::HOLD_TICKS
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic sample_tick,
  input  logic push_button_n,
  output logic pb_status,
  output logic pb_pressed,
  output logic pb_released,
  output logic pb_held
);

  localparam hold_cnt_t HOLD_MAX = hold_cnt_t'(HOLD_TICKS);

  logic                 sync_q1;
  logic                 sync_q2;
  logic [SHIFT_LEN-1:0] history;
  logic                 status_d;
  hold_cnt_t            hold_cnt;

  // Bring the raw active-low button into the clock domain as active-high.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync_q2 takes the old sync_q1, keeping two real flop stages.
      sync_q1 <= ~push_button_n;
      sync_q2 <= sync_q1;
    end
  end

  // Shift one synchronised sample into the history on every sample tick.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      history <= '0;
    end else if (sample_tick) begin
      history <= {history[SHIFT_LEN-2:0], sync_q2};
    end
  end

  // Debounced level rises on any pressed sample and falls only once the
  // whole history is clear; the delayed copy feeds the edge detectors.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      pb_status <= 1'b0;
      status_d  <= 1'b0;
    end else begin
      pb_status <= |history;
      status_d  <= pb_status;
    end
  end

  // Count samples of continuous press, saturating at the long-press threshold.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      hold_cnt <= '0;
    end else if (!pb_status) begin
      hold_cnt <= '0;
    end else if (sample_tick && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + hold_cnt_t'(1);
    end
  end

  assign pb_pressed  =  pb_status & ~status_d;
  assign pb_released = ~pb_status &  status_d;
  // Gating with pb_status drops the hold flag in the same cycle as the level,
  // one cycle before the counter itself clears.
  assign pb_held     =  pb_status & (hold_cnt == HOLD_MAX);

endmodule

// File: rtl/pb_debounce_detect.sv
// Push-button debounce and event detection: a shared sample-tick generator
// feeding one independent debounce channel per button.
module pb_debounce_detect
  import pb_debounce_pkg::*;
#(
  parameter int NUM_PB        = pb_debounce_pkg::NUM_PB,
  parameter int SAMPLE_PERIOD = pb_debounce_pkg::SAMPLE_PERIOD,
  parameter int SHIFT_LEN     = pb_debounce_pkg::SHIFT_LEN,
  parameter int HOLD_TICKS    = pb_debounce_pkg::HOLD_TICKS
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic [NUM_PB-1:0] PUSH_BUTTON_N_I,
  pb_debounce_if.master     pb_if
);

  localparam int                TICK_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              sample_tick;
  logic [NUM_PB-1:0] status_v;
  logic [NUM_PB-1:0] pressed_v;
  logic [NUM_PB-1:0] released_v;
  logic [NUM_PB-1:0] held_v;

  // Free-running sample counter 0..SAMPLE_PERIOD-1, shared by every channel.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign sample_tick = (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
    pb_debounce_channel #(
      .SHIFT_LEN  (SHIFT_LEN),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_chan (
      .CLOCK_50_I    (CLOCK_50_I),
      .resetn        (resetn),
      .sample_tick   (sample_tick),
      .push_button_n (PUSH_BUTTON_N_I[i]),
      .pb_status     (status_v[i]),
      .pb_pressed    (pressed_v[i]),
      .pb_released   (released_v[i]),
      .pb_held       (held_v[i])
    );
  end

  assign pb_if.sample_tick = sample_tick;
  assign pb_if.pb_status   = status_v;
  assign pb_if.pb_pressed  = pressed_v;
  assign pb_if.pb_released = released_v;
  assign pb_if.pb_held     = held_v;

endmodule

// File: tb/tb_pb_debounce_detect.sv
// Directed bench for pb_debounce_detect with SAMPLE_PERIOD=4, SHIFT_LEN=10,
// HOLD_TICKS=5. Edge numbers (ec) count rising edges since reset release and
// all expected edge numbers below are worked out by hand from that origin.
module tb_pb_debounce_detect;

  localparam int NPB = 4;
  localparam int SP  = 4;
  localparam int SL  = 10;
  localparam int HT  = 5;

  typedef struct {
    logic [3:0] pb_n;     // raw active-low buttons applied for the window
    int         ncyc;     // cycles in the window
    logic [3:0] status;   // pb_status at the last cycle
    logic [3:0] held;     // pb_held at the last cycle
    int         npress;   // pb_pressed bits seen in the window
    int         nrel;     // pb_released bits seen in the window
  } vec_t;

  logic           clk = 1'b0;
  logic           resetn;
  logic [NPB-1:0] pb_n;

  int n_applied    = 0;
  int n_miscompares = 0;
  int ec           = 0;
  int acc_press    = 0;
  int acc_rel      = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  pb_debounce_if #(.NUM_PB(NPB)) pb_if ();

  pb_debounce_detect #(
    .NUM_PB        (NPB),
    .SAMPLE_PERIOD (SP),
    .SHIFT_LEN     (SL),
    .HOLD_TICKS    (HT)
  ) dut (
    .CLOCK_50_I      (clk),
    .resetn          (resetn),
    .PUSH_BUTTON_N_I (pb_n),
    .pb_if           (pb_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s (ec=%0d): got %0h, expected %0h", name, ec, act, exp);
    end
  endtask

  // Advance one cycle, sample 1 ns after the rising edge, accumulate pulses.
  task automatic step();
    @(posedge clk);
    #1;
    ec++;
    acc_press += $countones(pb_if.pb_pressed);
    acc_rel   += $countones(pb_if.pb_released);
  endtask

  function automatic logic [16:0] all_outs();
    return {pb_if.sample_tick, pb_if.pb_status, pb_if.pb_pressed,
            pb_if.pb_released, pb_if.pb_held};
  endfunction

  initial begin
    int first_e;
    int held_rise;
    int held_fall;
    int st_rise;
    int st_fall;
    int hcnt;
    int rel_e;
    logic [3:0] first_val;
    logic [3:0] rel_val;

    // Clean press on PB0 from edge 12 to edge 112 (100 cycles).
    vecs[0] = '{4'b1110,  4, 4'b0000, 4'b0000, 0, 0};  // ec 13..16, not yet sampled
    vecs[1] = '{4'b1110,  1, 4'b0001, 4'b0000, 1, 0};  // ec 17, status rises, press pulse
    vecs[2] = '{4'b1110, 18, 4'b0001, 4'b0000, 0, 0};  // ec 18..35, hold count 4
    vecs[3] = '{4'b1110,  1, 4'b0001, 4'b0001, 0, 0};  // ec 36, 5th tick after rise
    vecs[4] = '{4'b1110, 76, 4'b0001, 4'b0001, 0, 0};  // ec 37..112, held saturates
    vecs[5] = '{4'b1111, 40, 4'b0001, 4'b0001, 0, 0};  // ec 113..152, history draining
    vecs[6] = '{4'b1111,  1, 4'b0000, 4'b0000, 0, 1};  // ec 153, 10 zero samples seen
    vecs[7] = '{4'b1111,  7, 4'b0000, 4'b0000, 0, 0};  // ec 154..160, idle

    pb_n   = '1;
    resetn = 1'b0;

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", 32'(all_outs()), 32'h0);
    end

    resetn = 1'b1;
    ec = 0;

    // Tick generator: high only on ec 3, 7, 11 (cycles 4, 8, 12 after release).
    for (int i = 0; i < 12; i++) begin
      step();
      check("tick_and_idle", 32'(all_outs()),
            ((ec % 4) == 3) ? 32'h10000 : 32'h0);
    end

    // Table-driven clean press / release of PB0.
    for (int v = 0; v < 8; v++) begin
      pb_n      = vecs[v].pb_n;
      acc_press = 0;
      acc_rel   = 0;
      for (int c = 0; c < vecs[v].ncyc; c++) step();
      check($sformatf("vec%0d_status", v), 32'(pb_if.pb_status), 32'(vecs[v].status));
      check($sformatf("vec%0d_held",   v), 32'(pb_if.pb_held),   32'(vecs[v].held));
      check($sformatf("vec%0d_npress", v), acc_press, vecs[v].npress);
      check($sformatf("vec%0d_nrel",   v), acc_rel,   vecs[v].nrel);
    end

    // Bounce on PB1: 3-cycle toggles from ec 160 for 30 cycles, then held.
    acc_press = 0;
    acc_rel   = 0;
    first_e   = -1;
    for (int i = 0; i < 60; i++) begin
      pb_n[1] = (i < 30) ? (((i / 3) % 2) == 1) : 1'b0;
      step();
      if (pb_if.pb_pressed[1] && first_e < 0) first_e = ec;
    end
    check("bounce_npress",     acc_press, 1);
    check("bounce_nrel",       acc_rel,   0);
    check("bounce_press_edge", first_e,   165);
    check("bounce_status",     32'(pb_if.pb_status), 32'h2);
    check("bounce_held",       32'(pb_if.pb_held),   32'h2);

    // Long press on PB2 for 40 cycles from ec 220.
    acc_press = 0;
    acc_rel   = 0;
    st_rise = -1; st_fall = -1; held_rise = -1; held_fall = -1;
    pb_n[2] = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i == 40) pb_n[2] = 1'b1;
      step();
      if (st_rise < 0 && pb_if.pb_status[2]) st_rise = ec;
      if (st_rise >= 0 && st_fall < 0 && !pb_if.pb_status[2]) st_fall = ec;
      if (held_rise < 0 && pb_if.pb_held[2]) held_rise = ec;
      if (held_rise >= 0 && held_fall < 0 && !pb_if.pb_held[2]) held_fall = ec;
    end
    check("long_status_rise", st_rise,   225);
    check("long_held_rise",   held_rise, 244);
    check("long_status_fall", st_fall,   301);
    check("long_held_fall",   held_fall, 301);
    check("long_npress",      acc_press, 1);
    check("long_nrel",        acc_rel,   1);

    // Saturation: hold PB2 for 200 cycles from ec 310; held must stay high
    // without a break from ec 336 until status falls at ec 553.
    hcnt      = 0;
    held_fall = -1;
    held_rise = -1;
    pb_n[2]   = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (i == 200) pb_n[2] = 1'b1;
      step();
      if (pb_if.pb_held[2]) hcnt++;
      if (held_rise < 0 && pb_if.pb_held[2]) held_rise = ec;
      if (held_rise >= 0 && held_fall < 0 && !pb_if.pb_held[2]) held_fall = ec;
    end
    check("sat_held_rise",   held_rise, 336);
    check("sat_held_cycles", hcnt,      217);
    check("sat_held_fall",   held_fall, 553);

    // Simultaneous press of PB0 and PB3 from ec 560, released at ec 580.
    acc_press = 0;
    acc_rel   = 0;
    first_e   = -1;
    rel_e     = -1;
    first_val = '0;
    rel_val   = '0;
    pb_n[0]   = 1'b0;
    pb_n[3]   = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (i == 20) begin
        pb_n[0] = 1'b1;
        pb_n[3] = 1'b1;
      end
      step();
      if (first_e < 0 && pb_if.pb_pressed != 4'b0000) begin
        first_e   = ec;
        first_val = pb_if.pb_pressed;
      end
      if (rel_e < 0 && pb_if.pb_released != 4'b0000) begin
        rel_e   = ec;
        rel_val = pb_if.pb_released;
      end
    end
    check("simul_press_edge", first_e,          565);
    check("simul_press_val",  32'(first_val),   32'h9);
    check("simul_npress",     acc_press,        2);
    check("simul_rel_edge",   rel_e,            621);
    check("simul_rel_val",    32'(rel_val),     32'h9);
    check("simul_nrel",       acc_rel,          2);

    // Reset mid-press: PB1 is still held; reset for 2 cycles.
    resetn = 1'b0;
    #1;
    check("midreset_immediate", 32'(all_outs()), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("midreset_hold", 32'(all_outs()), 32'h0);
    end
    resetn    = 1'b1;
    ec        = 0;
    acc_press = 0;
    acc_rel   = 0;
    first_e   = -1;
    first_val = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (first_e < 0 && pb_if.pb_pressed != 4'b0000) begin
        first_e   = ec;
        first_val = pb_if.pb_pressed;
      end
    end
    check("postreset_press_edge", first_e,        5);
    check("postreset_press_val",  32'(first_val), 32'h2);
    check("postreset_npress",     acc_press,      1);
    check("postreset_nrel",       acc_rel,        0);
    check("postreset_status",     32'(pb_if.pb_status), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
